// File: rtl/booth_mac_sequencer.sv
// Sequences signed 8x8 operand pairs through an external booth multiplier and
// accumulates the sign-extended products, reporting the sum on the pair marked last.
module booth_mac_sequencer #(
    parameter int ACC_WIDTH = 24,
    parameter int TIMEOUT   = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_multiplicand,
    input  logic [7:0]           in_multiplier,
    input  logic                 in_last,
    output logic                 mul_start,
    output logic [7:0]           mul_multiplicand,
    output logic [7:0]           mul_multiplier,
    input  logic                 mul_finish,
    input  logic [15:0]          mul_product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [7:0]           out_count,
    output logic                 out_overflow,
    output logic                 out_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACCUM,
        S_OUTPUT
    } state_t;

    localparam int WCW = $clog2(TIMEOUT + 1);

    state_t               state_q, state_d;
    logic [7:0]           a_q, a_d;
    logic [7:0]           b_q, b_d;
    logic                 last_q, last_d;
    logic                 drop_q, drop_d;
    logic [WCW-1:0]       wcnt_q, wcnt_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 err_q, err_d;

    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] sum;

    assign prod_ext = ACC_WIDTH'($signed(mul_product));
    assign sum      = acc_q + prod_ext;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            last_q  <= 1'b0;
            drop_q  <= 1'b0;
            wcnt_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
            wcnt_q  <= wcnt_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        last_d  = last_q;
        drop_d  = drop_q;
        wcnt_d  = wcnt_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_multiplicand;
                    b_d     = in_multiplier;
                    last_d  = in_last;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wcnt_d  = '0;
                drop_d  = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // The first WAIT cycle may still see the previous op's finish level.
                if (wcnt_q != '0 && mul_finish) begin
                    state_d = S_ACCUM;
                end else if (wcnt_q == WCW'(TIMEOUT - 1)) begin
                    drop_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_ACCUM;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_ACCUM: begin
                if (!drop_q) begin
                    acc_d = sum;
                    if (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1] &&
                        sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]) begin
                        ovf_d = 1'b1;
                    end
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                state_d = last_q ? S_OUTPUT : S_IDLE;
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready         = (state_q == S_IDLE);
    assign mul_start        = (state_q == S_ISSUE);
    assign mul_multiplicand = a_q;
    assign mul_multiplier   = b_q;
    assign out_valid        = (state_q == S_OUTPUT);
    assign out_sum          = acc_q;
    assign out_count        = cnt_q;
    assign out_overflow     = ovf_q;
    assign out_error        = err_q;

endmodule

// File: tb/tb_booth_mac_sequencer.sv
// Directed bench: a 24-bit and a 16-bit sequencer run in lockstep behind a
// behavioural multiplier model with programmable latency and a hang mode.
module tb_booth_mac_sequencer;

    localparam int AW = 24;
    localparam int TO = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       in_valid;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_last;
    logic       out_ready;

    wire          in_ready, mul_start, out_valid, ovf, err;
    wire [7:0]    mul_a, mul_b, out_count;
    wire [AW-1:0] out_sum;

    wire          in_ready16, mul_start16, out_valid16, ovf16, err16;
    wire [7:0]    mul_a16, mul_b16, out_count16;
    wire [15:0]   out_sum16;

    logic        m_fin   = 1'b0;
    logic [15:0] m_prod  = 16'h0000;
    int          m_cnt   = 0;
    int          mul_lat = 17;
    bit          hang    = 1'b0;

    int checks = 0;
    int errors = 0;
    int starts = 0;
    int dbl_starts = 0;
    int lockstep_bad = 0;
    logic prev_start = 1'b0;

    booth_mac_sequencer #(.ACC_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_multiplicand(in_a), .in_multiplier(in_b), .in_last(in_last),
        .mul_start(mul_start), .mul_multiplicand(mul_a), .mul_multiplier(mul_b),
        .mul_finish(m_fin), .mul_product(m_prod),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count),
        .out_overflow(ovf), .out_error(err)
    );

    booth_mac_sequencer #(.ACC_WIDTH(16), .TIMEOUT(TO)) dut16 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready16),
        .in_multiplicand(in_a), .in_multiplier(in_b), .in_last(in_last),
        .mul_start(mul_start16), .mul_multiplicand(mul_a16), .mul_multiplier(mul_b16),
        .mul_finish(m_fin), .mul_product(m_prod),
        .out_valid(out_valid16), .out_ready(out_ready),
        .out_sum(out_sum16), .out_count(out_count16),
        .out_overflow(ovf16), .out_error(err16)
    );

    function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] x;
        logic signed [15:0] y;
        x = {{8{a[7]}}, a};
        y = {{8{b[7]}}, b};
        return 16'(x * y);
    endfunction

    // Multiplier model: finish drops on start, rises mul_lat edges later.
    always @(posedge clk) begin
        if (mul_start) begin
            m_fin <= 1'b0;
            m_cnt <= mul_lat;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && !hang) begin
                m_fin  <= 1'b1;
                m_prod <= smul(mul_a, mul_b);
            end
        end
    end

    always @(negedge clk) begin
        if (mul_start) starts++;
        if (mul_start && prev_start) dbl_starts++;
        prev_start <= mul_start;
        if (mul_start16 !== mul_start || in_ready16 !== in_ready || out_valid16 !== out_valid ||
            mul_a16 !== mul_a || mul_b16 !== mul_b || out_count16 !== out_count || err16 !== err)
            lockstep_bad++;
    end

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic l);
        int n;
        in_a = a; in_b = b; in_last = l; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_accept in_ready=%0b required 1 (a=%0d b=%0d)", in_ready, $signed(a), $signed(b));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL out_valid_wait out_valid=%0b required 1 after %0d cycles", out_valid, n);
        end
    endtask

    task automatic finish_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || mul_start !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl out_valid=%0b mul_start=%0b in_ready=%0b required 0 0 1", out_valid, mul_start, in_ready);
        end
        checks++;
        if (mul_a !== 8'h00 || mul_b !== 8'h00) begin
            errors++;
            $display("FAIL reset_operands a=%h b=%h required 00 00", mul_a, mul_b);
        end
        checks++;
        if (out_sum !== 24'h000000 || out_count !== 8'h00 || ovf !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_result sum=%h count=%0d ovf=%0b err=%0b required 0 0 0 0", out_sum, out_count, ovf, err);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        int n;
        int s0;
        s0 = starts;
        send_pair(8'd3, 8'hFC, 1'b1);
        wait_out(n);
        checks++;
        if (out_sum !== 24'hFFFFF4 || out_count !== 8'd1) begin
            errors++;
            $display("FAIL single_sum sum=%0d count=%0d required -12 1", $signed(out_sum), out_count);
        end
        checks++;
        if (ovf !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL single_flags ovf=%0b err=%0b required 0 0", ovf, err);
        end
        checks++;
        if (starts - s0 != 1) begin
            errors++;
            $display("FAIL single_starts pulses=%0d required 1", starts - s0);
        end
        finish_out();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 24'h0) begin
            errors++;
            $display("FAIL single_release out_valid=%0b in_ready=%0b sum=%0d required 0 1 0", out_valid, in_ready, $signed(out_sum));
        end
        $display("test_single sum=%0d count=%0d", $signed(out_sum), out_count);
    endtask

    task automatic test_sequence();
        int n;
        mul_lat = 1;
        send_pair(8'd5, 8'd6, 1'b0);
        send_pair(8'hF9, 8'd8, 1'b0);
        send_pair(8'd127, 8'd127, 1'b1);
        wait_out(n);
        checks++;
        if (out_sum !== 24'd16103 || out_count !== 8'd3) begin
            errors++;
            $display("FAIL seq_sum sum=%0d count=%0d required 16103 3", $signed(out_sum), out_count);
        end
        checks++;
        if (dbl_starts != 0) begin
            errors++;
            $display("FAIL seq_start_pulse double=%0d required 0", dbl_starts);
        end
        finish_out();
        mul_lat = 17;
        $display("test_sequence sum=16103 expected, count=3 expected");
    endtask

    task automatic test_extremes();
        int n;
        send_pair(8'h80, 8'h80, 1'b1);
        wait_out(n);
        checks++;
        if (out_sum !== 24'd16384 || out_sum16 !== 16'h4000 || ovf16 !== 1'b0) begin
            errors++;
            $display("FAIL ext_single sum=%0d sum16=%h ovf16=%0b required 16384 4000 0", $signed(out_sum), out_sum16, ovf16);
        end
        finish_out();
        send_pair(8'h80, 8'h80, 1'b0);
        send_pair(8'h80, 8'h80, 1'b1);
        wait_out(n);
        checks++;
        if (out_sum16 !== 16'h8000 || ovf16 !== 1'b1) begin
            errors++;
            $display("FAIL ext_ovf16 sum16=%h ovf16=%0b required 8000 1", out_sum16, ovf16);
        end
        checks++;
        if (out_sum !== 24'd32768 || ovf !== 1'b0 || out_count !== 8'd2) begin
            errors++;
            $display("FAIL ext_wide sum=%0d ovf=%0b count=%0d required 32768 0 2", $signed(out_sum), ovf, out_count);
        end
        $display("test_extremes sum16=%h ovf16=%0b", out_sum16, ovf16);
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 24'd32768 ||
                out_count !== 8'd2 || out_sum16 !== 16'h8000 || ovf16 !== 1'b1)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold unstable_cycles=%0d required 0", bad);
        end
        finish_out();
        send_pair(8'd2, 8'd3, 1'b1);
        wait_out(n);
        checks++;
        if (out_sum !== 24'd6 || out_count !== 8'd1 || ovf16 !== 1'b0 || out_sum16 !== 16'd6) begin
            errors++;
            $display("FAIL bp_restart sum=%0d count=%0d ovf16=%0b sum16=%0d required 6 1 0 6", $signed(out_sum), out_count, ovf16, out_sum16);
        end
        finish_out();
        $display("test_backpressure held 10 cycles");
    endtask

    task automatic test_timeout();
        int n;
        hang = 1'b1;
        send_pair(8'd2, 8'd2, 1'b1);
        wait_out(n);
        checks++;
        if (err !== 1'b1 || out_count !== 8'd0 || out_sum !== 24'd0) begin
            errors++;
            $display("FAIL timeout_result err=%0b count=%0d sum=%0d required 1 0 0", err, out_count, $signed(out_sum));
        end
        checks++;
        if (n < TO || n > TO + 4) begin
            errors++;
            $display("FAIL timeout_latency cycles=%0d required %0d..%0d", n, TO, TO + 4);
        end
        finish_out();
        hang = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear err=%0b required 0", err);
        end
        $display("test_timeout cycles=%0d", n);
    endtask

    task automatic test_reset_mid_wait();
        int n;
        send_pair(8'd5, 8'd5, 1'b0);
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        send_pair(8'd9, 8'd9, 1'b1);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || mul_start !== 1'b0 ||
            mul_a !== 8'h00 || mul_b !== 8'h00) begin
            errors++;
            $display("FAIL midrst_ctrl out_valid=%0b in_ready=%0b start=%0b a=%h b=%h required 0 1 0 00 00",
                     out_valid, in_ready, mul_start, mul_a, mul_b);
        end
        checks++;
        if (out_sum !== 24'd0 || out_count !== 8'd0) begin
            errors++;
            $display("FAIL midrst_result sum=%0d count=%0d required 0 0", $signed(out_sum), out_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        send_pair(8'd1, 8'd1, 1'b1);
        wait_out(n);
        checks++;
        if (out_sum !== 24'd1 || out_count !== 8'd1) begin
            errors++;
            $display("FAIL midrst_after sum=%0d count=%0d required 1 1", $signed(out_sum), out_count);
        end
        finish_out();
        $display("test_reset_mid_wait sum=1 expected");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_single();
        test_sequence();
        test_extremes();
        test_backpressure();
        test_timeout();
        test_reset_mid_wait();
        checks++;
        if (lockstep_bad != 0) begin
            errors++;
            $display("FAIL lockstep cycles=%0d required 0", lockstep_bad);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_mac_sequencer.md
# booth_mac_sequencer

Multiply-accumulate sequencer that sits directly in front of and behind the `booth` multiplier. It accepts signed 8-bit operand pairs over a valid/ready stream, issues each pair to the multiplier with a one-cycle `start` pulse, and waits for `finish`. It then sign-extends and accumulates the 16-bit signed product. On the pair marked last, it presents the running sum, pair count and status flags on a held output handshake.

## Interface

Parameters:
- `ACC_WIDTH`, default 24: accumulator width in bits; must be ≥ 16.
- `TIMEOUT`, default 32: maximum number of WAIT cycles allowed for `mul_finish` before the pair is abandoned.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  sequencer can accept a pair.
- `in_multiplicand`  in  8  signed operand A.
- `in_multiplier`  in  8  signed operand B.
- `in_last`  in  1  this pair closes the current accumulation.
- `mul_start`  out  1  start pulse to the multiplier.
- `mul_multiplicand`  out  8  registered operand A to the multiplier.
- `mul_multiplier`  out  8  registered operand B to the multiplier.
- `mul_finish`  in  1  multiplier done (level; stays high until the next start).
- `mul_product`  in  16  signed product from the multiplier.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  ACC_WIDTH  signed accumulated sum.
- `out_count`  out  8  number of products accumulated.
- `out_overflow`  out  1  a signed overflow occurred in this accumulation (sticky).
- `out_error`  out  1  a multiplier timeout occurred in this accumulation (sticky).

## Operation

- FSM states: IDLE, ISSUE, WAIT, ACCUM, OUTPUT.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, register A, B and `last`, then go to ISSUE.
- **ISSUE**
  - `mul_start`=1 for exactly this one cycle. Go to WAIT; clear the wait counter.
- **WAIT**
  - `mul_finish` is ignored in the first WAIT cycle, because the multiplier is in its load state and stale `finish` from the prior op has only just dropped. It is sampled on every later WAIT cycle.
  - When `mul_finish`=1, go to ACCUM.
  - When the wait counter reaches `TIMEOUT`, set the sticky error flag and go to ACCUM with the accumulate suppressed: the pair is dropped and the count is unchanged.
- **ACCUM**
  - acc ← acc + sign_extend(`mul_product`, `ACC_WIDTH`), modulo 2^`ACC_WIDTH`.
  - Signed overflow of this add sets the sticky overflow flag. Overflow means both operands have the same sign and the result's sign differs.
  - The count increments and saturates at 255.
  - Then go to OUTPUT if `last` was registered, else to IDLE.
- **OUTPUT**
  - `out_valid`=1; `out_sum`, `out_count`, `out_overflow` and `out_error` are held stable.
  - On `out_ready`: clear acc, count and both flags, then go to IDLE.
- `mul_multiplicand` and `mul_multiplier` stay stable from ISSUE until ACCUM exits. They change only on acceptance in IDLE.
- `in_ready`=0 in every state except IDLE, so there is at most one pair in flight.
- Reset values:
  - state=IDLE, acc=0, count=0, flags=0.
  - `mul_start`=0, `mul_multiplicand`=0, `mul_multiplier`=0.
  - `out_valid`=0, `out_sum`=0, `out_count`=0.
- Reset mid-operation aborts any in-flight pair and discards the partial sum. The multiplier has no reset; the next ISSUE pulse restarts it, so no flush is needed.

## Timing

- Pair accepted at edge 0:
  - ISSUE occupies cycle 1.
  - WAIT starts at cycle 2.
  - ACCUM is the cycle after the `mul_finish` sample.
  - OUTPUT or IDLE follows on the next edge.
- Sequencer overhead is 3 cycles plus the multiplier latency; the `booth` latency is at most 18 cycles, below the default `TIMEOUT`.
- Next `in_ready` rises 1 cycle after ACCUM for a non-last pair, or 1 cycle after the `out_ready` handshake.
- `out_valid` is held indefinitely under backpressure. `out_ready` asserted outside OUTPUT is ignored.
- `in_valid` with `in_ready`=0 is ignored; the source must hold the pair until it is accepted.

## Test plan

- **Single pair.** Pair (3, −4, last) with the real `booth` attached → one `mul_start` pulse; `out_sum`=−12, `out_count`=1, flags 0.
- **Sequence of three.** Pairs (5,6), (−7,8), (127,127, last) → `out_sum`=16103, `out_count`=3; `mul_start` is never high for 2 consecutive cycles.
- **Extremes and overflow.**
  - Default width: (−128,−128, last) → `out_sum`=16384.
  - With `ACC_WIDTH`=16: (−128,−128), (−128,−128, last) → `out_sum`=0x8000, `out_overflow`=1.
- **Output backpressure.** Hold `out_ready`=0 for 10 cycles in OUTPUT → `out_valid` and all outputs stable, `in_ready`=0. After `out_ready`, the next accumulation starts from 0 and flags are cleared.
- **Timeout.** Multiplier stub never raises `mul_finish`; send (2,2, last) → after `TIMEOUT` WAIT cycles, `out_valid` with `out_error`=1, `out_count`=0, `out_sum`=0.
- **Reset mid-WAIT.** Drop `reset_n` mid-WAIT → all outputs return to their reset values immediately. A new pair (1,1, last) then yields `out_sum`=1, `out_count`=1.
